ovc_status_ctrl: RTL and testbench

//  Per-output-VC resource controller feeding the combined VC/switch allocator.

---
 rtl/ovc_status_ctrl_if.sv | 25 ++
 rtl/ovc_status_ctrl.sv | 112 +++++++++++
 tb/tb_ovc_status_ctrl.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/ovc_status_ctrl_if.sv
// Allocator-side bundle for ovc_status_ctrl: per-OVC events in, availability/status out.
// master = allocator / credit logic, slave = ovc_status_ctrl.
interface ovc_status_ctrl_if #(
  parameter int PV = 20,
  parameter int P  = 5
);
  logic [PV-1:0] credit_in_all;
  logic [PV-1:0] flit_sent_all;
  logic [PV-1:0] ovc_allocated_all;
  logic [PV-1:0] ovc_released_all;
  logic [PV-1:0] ovc_avail_all;
  logic [PV-1:0] ovc_not_full_all;
  logic [P-1:0]  port_has_free_all;
  logic [PV-1:0] credit_err_all;

  modport master (
    output credit_in_all, flit_sent_all, ovc_allocated_all, ovc_released_all,
    input  ovc_avail_all, ovc_not_full_all, port_has_free_all, credit_err_all
  );

  modport slave (
    input  credit_in_all, flit_sent_all, ovc_allocated_all, ovc_released_all,
    output ovc_avail_all, ovc_not_full_all, port_has_free_all, credit_err_all
  );
endinterface

// File: rtl/ovc_status_ctrl.sv
// Per-output-VC credit counters and allocation FSMs feeding the VC/switch allocator.
// Optional macro OVC_CONSERVATIVE_REALLOC_EN adds a DRAIN state that holds a released OVC until all credits return.
module ovc_status_ctrl #(
  parameter int V = 4,
  parameter int P = 5,
  parameter int B = 4
) (
  input  logic               clk,
  input  logic               reset,
  ovc_status_ctrl_if.slave   bus
);

  localparam int PV = V * P;
  localparam int CW = $clog2(B + 1);
  localparam logic [CW-1:0] B_CNT = CW'(B);
  localparam logic [CW-1:0] ONE   = CW'(1);

`ifdef OVC_CONSERVATIVE_REALLOC_EN
  typedef enum logic [1:0] {IDLE = 2'd0, ALLOC = 2'd1, DRAIN = 2'd2} ovc_state_e;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, ALLOC = 2'd1} ovc_state_e;
`endif

  logic [PV-1:0] avail_vec;
  logic [PV-1:0] not_full_vec;
  logic [PV-1:0] err_vec;

  for (genvar i = 0; i < PV; i++) begin : g_ovc
    ovc_state_e    state_q, state_next;
    logic [CW-1:0] cnt_q, cnt_next;
    logic          cnt_err, fsm_err;
    logic          avail_q, not_full_q, err_q;

    logic credit, sent, alloc, release_evt;
    assign credit      = bus.credit_in_all[i];
    assign sent        = bus.flit_sent_all[i];
    assign alloc       = bus.ovc_allocated_all[i];
    assign release_evt = bus.ovc_released_all[i];

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
      cnt_next = cnt_q;
      cnt_err  = 1'b0;
      if (credit && !sent) begin
        if (cnt_q == B_CNT) cnt_err  = 1'b1;
        else                cnt_next = cnt_q + ONE;
      end else if (sent && !credit) begin
        if (cnt_q == '0) cnt_err  = 1'b1;
        else             cnt_next = cnt_q - ONE;
      end
    end

    // Each state honours only its own event; the other one is an illegal request and flagged.
    always_comb begin
      state_next = state_q;
      fsm_err    = 1'b0;
      case (state_q)
        IDLE: begin
          if (alloc)       state_next = ALLOC;
          if (release_evt) fsm_err    = 1'b1;
        end
        ALLOC: begin
          if (alloc) fsm_err = 1'b1;
          if (release_evt) begin
`ifdef OVC_CONSERVATIVE_REALLOC_EN
            state_next = (cnt_next == B_CNT) ? IDLE : DRAIN;
`else
            state_next = IDLE;
`endif
          end
        end
`ifdef OVC_CONSERVATIVE_REALLOC_EN
        DRAIN: begin
          if (alloc || release_evt) fsm_err    = 1'b1;
          if (cnt_next == B_CNT)    state_next = IDLE;
        end
`endif
        default: state_next = IDLE;
      endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops sample pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        state_q    <= IDLE;
        cnt_q      <= B_CNT;
        avail_q    <= 1'b1;
        not_full_q <= 1'b1;
        err_q      <= 1'b0;
      end else begin
        state_q    <= state_next;
        cnt_q      <= cnt_next;
        avail_q    <= (state_next == IDLE);
        not_full_q <= (cnt_next != '0);
        err_q      <= err_q | cnt_err | fsm_err;
      end
    end

    assign avail_vec[i]    = avail_q;
    assign not_full_vec[i] = not_full_q;
    assign err_vec[i]      = err_q;
  end

  for (genvar p = 0; p < P; p++) begin : g_port
    assign bus.port_has_free_all[p] = |avail_vec[p*V +: V];
  end

  assign bus.ovc_avail_all    = avail_vec;
  assign bus.ovc_not_full_all = not_full_vec;
  assign bus.credit_err_all   = err_vec;

endmodule

// File: tb/tb_ovc_status_ctrl.sv
// Self-checking bench for ovc_status_ctrl: directed scenarios plus randomized traffic
// compared each cycle against an in-flight/ownership model of every OVC.
module tb_ovc_status_ctrl;
  localparam int V  = 4;
  localparam int P  = 5;
  localparam int B  = 4;
  localparam int PV = V * P;
`ifdef OVC_CONSERVATIVE_REALLOC_EN
  localparam bit CONSERVATIVE = 1'b1;
`else
  localparam bit CONSERVATIVE = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  ovc_status_ctrl_if #(.PV(PV), .P(P)) bus ();

  ovc_status_ctrl #(.V(V), .P(P), .B(B)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  // Model: flits downstream (B - credits), ownership by a packet, waiting for drain, sticky error.
  int in_flight [PV];
  bit owned     [PV];
  bit draining  [PV];
  bit err_m     [PV];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < PV; i++) begin
      in_flight[i] = 0; owned[i] = 0; draining[i] = 0; err_m[i] = 0;
    end
  endtask

  task automatic model_step(input logic [PV-1:0] c, s, a, r);
    for (int i = 0; i < PV; i++) begin
      int nf;
      bit was_idle, was_owned, was_drain;
      was_idle  = !owned[i] && !draining[i];
      was_owned = owned[i];
      was_drain = draining[i];
      nf = in_flight[i] + int'(s[i]) - int'(c[i]);
      if (nf > B) begin nf = B; err_m[i] = 1; end
      if (nf < 0) begin nf = 0; err_m[i] = 1; end
      if (a[i]) begin
        if (was_idle) owned[i] = 1;
        else          err_m[i] = 1;
      end
      if (r[i]) begin
        if (was_owned) begin
          owned[i]    = 0;
          draining[i] = CONSERVATIVE && (nf != 0);
        end else begin
          err_m[i] = 1;
        end
      end
      if (was_drain && nf == 0) draining[i] = 0;
      in_flight[i] = nf;
    end
  endtask

  task automatic compare_all(input string phase);
    logic [PV-1:0] e_av, e_nf, e_err;
    logic [P-1:0]  e_pf;
    for (int i = 0; i < PV; i++) begin
      e_av[i]  = !owned[i] && !draining[i];
      e_nf[i]  = in_flight[i] < B;
      e_err[i] = err_m[i];
    end
    for (int p = 0; p < P; p++) e_pf[p] = |e_av[p*V +: V];
    check({phase, ".avail"},    32'(bus.ovc_avail_all),     32'(e_av));
    check({phase, ".not_full"}, 32'(bus.ovc_not_full_all),  32'(e_nf));
    check({phase, ".port_free"},32'(bus.port_has_free_all), 32'(e_pf));
    check({phase, ".err"},      32'(bus.credit_err_all),    32'(e_err));
  endtask

  // Drive one cycle of events, clock it, advance the model and compare after the edge.
  task automatic step(input string phase, input logic [PV-1:0] c, s, a, r);
    bus.credit_in_all     = c;
    bus.flit_sent_all     = s;
    bus.ovc_allocated_all = a;
    bus.ovc_released_all  = r;
    @(posedge clk);
    model_step(c, s, a, r);
    #1;
    bus.credit_in_all     = '0;
    bus.flit_sent_all     = '0;
    bus.ovc_allocated_all = '0;
    bus.ovc_released_all  = '0;
    compare_all(phase);
  endtask

  function automatic logic [PV-1:0] bit_of(input int i);
    logic [PV-1:0] v;
    v = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  task automatic do_reset();
    reset = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  initial begin
    logic [PV-1:0] z, o3;
    z  = '0;
    o3 = bit_of(3);
    bus.credit_in_all     = '0;
    bus.flit_sent_all     = '0;
    bus.ovc_allocated_all = '0;
    bus.ovc_released_all  = '0;

    // 1: reset state
    do_reset();
    compare_all("reset");
    check("reset.avail_ones", 32'(bus.ovc_avail_all), 32'(20'hFFFFF));
    check("reset.err_zero",   32'(bus.credit_err_all), 32'd0);

    // 2: allocate OVC 3 and send B flits
    step("alloc3", z, z, o3, z);
    check("alloc3.avail_bit", 32'(bus.ovc_avail_all[3]), 32'd0);
    for (int k = 0; k < B; k++) step("send3", z, o3, z, z);
    check("send3.not_full_bit", 32'(bus.ovc_not_full_all[3]), 32'd0);

    // 3: empty counter, simultaneous credit and flit, then a lone credit
    step("both3", o3, o3, z, z);
    check("both3.not_full_bit", 32'(bus.ovc_not_full_all[3]), 32'd0);
    check("both3.err_bit",      32'(bus.credit_err_all[3]),   32'd0);
    step("credit3", o3, z, z, z);
    check("credit3.not_full_bit", 32'(bus.ovc_not_full_all[3]), 32'd1);

    // 4: release with 2 credits outstanding
    step("credit3b", o3, z, z, z);
    step("release3", z, z, z, o3);
    check("release3.avail_bit", 32'(bus.ovc_avail_all[3]), 32'(!CONSERVATIVE));
    step("drain3a", o3, z, z, z);
    check("drain3a.avail_bit", 32'(bus.ovc_avail_all[3]), 32'(!CONSERVATIVE));
    step("drain3b", o3, z, z, z);
    check("drain3b.avail_bit", 32'(bus.ovc_avail_all[3]), 32'd1);
    check("drain3b.err_bit",   32'(bus.credit_err_all[3]), 32'd0);

    // 5: overflow on a full counter, double allocate
    step("ovf0", bit_of(0), z, z, z);
    check("ovf0.err_bit", 32'(bus.credit_err_all[0]), 32'd1);
    step("alloc1", z, z, bit_of(1), z);
    step("realloc1", z, z, bit_of(1), z);
    check("realloc1.err_bit", 32'(bus.credit_err_all[1]), 32'd1);
    check("realloc1.avail_bit", 32'(bus.ovc_avail_all[1]), 32'd0);
    step("hold", z, z, z, z);
    check("hold.err_sticky", 32'(bus.credit_err_all[1:0]), 32'd3);
    step("send1_after", z, bit_of(1), z, z);
    step("release1", z, z, z, bit_of(1));
    step("credit1", bit_of(1), z, z, z);

    // underflow: drain OVC 2 fully, then one extra flit
    for (int k = 0; k < B; k++) step("send2", z, bit_of(2), z, z);
    step("udf2", z, bit_of(2), z, z);
    check("udf2.err_bit", 32'(bus.credit_err_all[2]), 32'd1);
    check("udf2.not_full_bit", 32'(bus.ovc_not_full_all[2]), 32'd0);

    // 6: async reset while OVC 5 has one credit left (DRAIN when conservative)
    do_reset();
    step("alloc5", z, z, bit_of(5), z);
    for (int k = 0; k < B - 1; k++) step("send5", z, bit_of(5), z, z);
    step("release5", z, z, z, bit_of(5));
    step("err5", z, z, bit_of(6), bit_of(6));
    check("mid.avail5", 32'(bus.ovc_avail_all[5]), 32'(!CONSERVATIVE));
    reset = 1'b0;
    model_reset();
    #1;
    compare_all("async_reset");
    check("async_reset.err_zero", 32'(bus.credit_err_all), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    step("post_reset", z, z, z, z);

    // Random traffic, mostly legal with occasional illegal events
    for (int cyc = 0; cyc < 400; cyc++) begin
      logic [PV-1:0] c, s, a, r;
      for (int i = 0; i < PV; i++) begin
        bit rare;
        rare = ($urandom_range(0, 63) == 0);
        s[i] = ((in_flight[i] < B) && ($urandom_range(0, 2) == 0)) || rare;
        c[i] = ((in_flight[i] > 0) && ($urandom_range(0, 2) == 0)) || ($urandom_range(0, 99) == 0);
        a[i] = (!owned[i] && !draining[i] && ($urandom_range(0, 7) == 0)) || ($urandom_range(0, 127) == 0);
        r[i] = (owned[i] && ($urandom_range(0, 5) == 0)) || ($urandom_range(0, 127) == 0);
      end
      step("rand", c, s, a, r);
      if (cyc == 200) begin
        do_reset();
        compare_all("rand_reset");
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end
endmodule
